// File: rtl/frame_fetch_ctrl.sv
// Frame-buffer fetch engine: streams one frame from SDRAM into the async pixel FIFO
// using single-outstanding Avalon-MM burst reads, throttled by the FIFO almost-full flag.
module frame_fetch_ctrl #(
  parameter int unsigned           addr_width  = 32,
  parameter int unsigned           data_width  = 32,
  parameter logic [addr_width-1:0] base_addr   = '0,
  parameter int unsigned           frame_words = 307200,
  parameter int unsigned           burst_len   = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  fifo_almost_full,
  output logic [addr_width-1:0] avm_address,
  output logic                  avm_read,
  output logic [6:0]            avm_burstcount,
  input  logic                  avm_waitrequest,
  input  logic [data_width-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  output logic                  fifo_wr_en,
  output logic [data_width-1:0] fifo_wr_data,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  start_overrun
);

  localparam int unsigned           CNT_W      = $clog2(frame_words + 1);
  localparam logic [CNT_W-1:0]      FRAME_CNT  = CNT_W'(frame_words);
  localparam logic [addr_width-1:0] WORD_BYTES = addr_width'(data_width / 8);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    REQ,
    DATA,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      req_remaining_q, req_remaining_d;
  logic [CNT_W-1:0]      rx_remaining_q, rx_remaining_d;
  logic [6:0]            beats_left_q, beats_left_d;
  logic [addr_width-1:0] avm_address_q, avm_address_d;
  logic                  avm_read_q, avm_read_d;
  logic [6:0]            avm_burstcount_q, avm_burstcount_d;
  logic                  fifo_wr_en_q, fifo_wr_en_d;
  logic [data_width-1:0] fifo_wr_data_q, fifo_wr_data_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  start_overrun_q, start_overrun_d;
  logic                  beat_accept;

  // Returned beats are only meaningful while a granted burst is being drained.
  assign beat_accept = (state_q == DATA) && avm_readdatavalid;

  always_comb begin
    state_d          = state_q;
    req_remaining_d  = req_remaining_q;
    rx_remaining_d   = rx_remaining_q;
    beats_left_d     = beats_left_q;
    avm_address_d    = avm_address_q;
    avm_read_d       = avm_read_q;
    avm_burstcount_d = avm_burstcount_q;
    busy_d           = busy_q;
    frame_done_d     = 1'b0;
    start_overrun_d  = start_overrun_q;
    fifo_wr_en_d     = beat_accept;
    fifo_wr_data_d   = beat_accept ? avm_readdata : fifo_wr_data_q;

    if (frame_start && busy_q) begin
      start_overrun_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          req_remaining_d = FRAME_CNT;
          rx_remaining_d  = FRAME_CNT;
          avm_address_d   = base_addr;
          busy_d          = 1'b1;
          state_d         = CHECK;
        end
      end
      CHECK: begin
        if (req_remaining_q == '0) begin
          state_d = DONE;
        end else if (!fifo_almost_full) begin
          if (32'(req_remaining_q) > burst_len) begin
            avm_burstcount_d = 7'(burst_len);
          end else begin
            avm_burstcount_d = 7'(req_remaining_q);
          end
          avm_read_d = 1'b1;
          state_d    = REQ;
        end
      end
      REQ: begin
        if (avm_read_q && !avm_waitrequest) begin
          avm_read_d      = 1'b0;
          beats_left_d    = avm_burstcount_q;
          req_remaining_d = req_remaining_q - CNT_W'(avm_burstcount_q);
          avm_address_d   = avm_address_q + addr_width'(avm_burstcount_q) * WORD_BYTES;
          state_d         = DATA;
        end
      end
      DATA: begin
        if (beat_accept) begin
          beats_left_d   = beats_left_q - 7'd1;
          rx_remaining_d = rx_remaining_q - CNT_W'(1);
          if (beats_left_q == 7'd1) begin
            state_d = (req_remaining_q == '0) ? DONE : CHECK;
          end
        end
      end
      DONE: begin
        // The final beat's FIFO write is on the bus during this cycle, so the
        // done pulse lands exactly one cycle after it.
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      req_remaining_q  <= '0;
      rx_remaining_q   <= '0;
      beats_left_q     <= '0;
      avm_address_q    <= base_addr;
      avm_read_q       <= 1'b0;
      avm_burstcount_q <= '0;
      fifo_wr_en_q     <= 1'b0;
      fifo_wr_data_q   <= '0;
      busy_q           <= 1'b0;
      frame_done_q     <= 1'b0;
      start_overrun_q  <= 1'b0;
    end else begin
      state_q          <= state_d;
      req_remaining_q  <= req_remaining_d;
      rx_remaining_q   <= rx_remaining_d;
      beats_left_q     <= beats_left_d;
      avm_address_q    <= avm_address_d;
      avm_read_q       <= avm_read_d;
      avm_burstcount_q <= avm_burstcount_d;
      fifo_wr_en_q     <= fifo_wr_en_d;
      fifo_wr_data_q   <= fifo_wr_data_d;
      busy_q           <= busy_d;
      frame_done_q     <= frame_done_d;
      start_overrun_q  <= start_overrun_d;
    end
  end

  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_burstcount = avm_burstcount_q;
  assign fifo_wr_en     = fifo_wr_en_q;
  assign fifo_wr_data   = fifo_wr_data_q;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;
  assign start_overrun  = start_overrun_q;

endmodule

// File: tb/tb_frame_fetch_ctrl.sv
// Bench for frame_fetch_ctrl: Avalon slave model returning address-derived data,
// frame-level reference model, scenario table plus directed restart/overrun/reset sequences.
module tb_frame_fetch_ctrl;

  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;
  localparam int unsigned FW    = 100;
  localparam int unsigned BL    = 16;
  localparam logic [31:0] BASE  = 32'hFFFF_FF00;
  localparam int unsigned NB    = (FW + BL - 1) / BL;
  localparam int unsigned NSCEN = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_start;
  logic          fifo_almost_full;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic [6:0]    avm_burstcount;
  logic          avm_waitrequest;
  logic [DW-1:0] avm_readdata;
  logic          avm_readdatavalid;
  logic          fifo_wr_en;
  logic [DW-1:0] fifo_wr_data;
  logic          busy;
  logic          frame_done;
  logic          start_overrun;

  frame_fetch_ctrl #(
    .addr_width (AW),
    .data_width (DW),
    .base_addr  (BASE),
    .frame_words(FW),
    .burst_len  (BL)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .frame_start      (frame_start),
    .fifo_almost_full (fifo_almost_full),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_burstcount   (avm_burstcount),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .fifo_wr_en       (fifo_wr_en),
    .fifo_wr_data     (fifo_wr_data),
    .busy             (busy),
    .frame_done       (frame_done),
    .start_overrun    (start_overrun)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory content is a fixed scramble of the byte address.
  function automatic logic [31:0] mix(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
  endfunction

  function automatic logic [31:0] exp_addr(input int unsigned k);
    return BASE + 32'(k * BL * 4);
  endfunction

  function automatic logic [6:0] exp_bc(input int unsigned k);
    int unsigned left;
    left = FW - k * BL;
    return (left < BL) ? 7'(left) : 7'(BL);
  endfunction

  // Knobs: written only by the main sequence.
  int unsigned k_stall_burst = 99;
  int unsigned k_stall_n     = 0;
  int unsigned k_lat         = 1;
  bit          k_gaps        = 1'b0;
  bit          k_rnd         = 1'b0;
  int unsigned k_af_mode     = 0;

  // Reference-model and slave state: written only by the model process.
  bit          exp_busy = 1'b0, exp_done = 1'b0, exp_ovr = 1'b0, chk_rst = 1'b0;
  bit          prev_read = 1'b0;
  int unsigned wr_idx = 0, burst_idx = 0, frame_grants = 0;
  logic [31:0] last_grant_addr = '0;
  int unsigned negcnt = 0, af_drop_at = 0, af_hold = 0, af_phase = 0;
  bit          af_check_pending = 1'b0;
  int unsigned beats_pend = 0, lat_cnt = 0, stall_left = 0;
  logic [31:0] beat_addr = '0, req_addr = '0;
  logic [6:0]  req_bc = '0;
  bit          in_req = 1'b0;

  task automatic monitor_step();
    bit final_now, nb, nd, no;
    if (chk_rst) begin
      check1("rst_avm_read", avm_read, 1'b0);
      check ("rst_avm_address", avm_address, BASE);
      check ("rst_burstcount", 32'(avm_burstcount), 32'd0);
      check1("rst_fifo_wr_en", fifo_wr_en, 1'b0);
      check ("rst_fifo_wr_data", fifo_wr_data, 32'd0);
    end
    check1("busy", busy, exp_busy);
    check1("frame_done", frame_done, exp_done);
    check1("start_overrun", start_overrun, exp_ovr);

    final_now = 1'b0;
    if (fifo_wr_en !== 1'b0) begin
      check1("wr_allowed", (exp_busy && wr_idx < FW), 1'b1);
      if (exp_busy && wr_idx < FW) begin
        check("wr_data", fifo_wr_data, mix(BASE + 32'(wr_idx * 4)));
        wr_idx++;
        final_now = (wr_idx == FW);
      end
    end
    if (avm_read === 1'b1 && !prev_read) check1("read_rise_af_low", fifo_almost_full, 1'b0);
    if (af_check_pending && negcnt == af_drop_at + 1) begin
      check1("af_release_issue", avm_read, 1'b1);
      af_check_pending = 1'b0;
    end
    prev_read = (avm_read === 1'b1);

    nb = final_now ? 1'b0 : exp_busy;
    nd = final_now;
    no = exp_ovr;
    if (frame_start === 1'b1) begin
      if (exp_busy) no = 1'b1;
      else begin
        nb = 1'b1;
        wr_idx = 0;
        burst_idx = 0;
        frame_grants = 0;
        af_phase = 0;
        af_check_pending = 1'b0;
      end
    end
    chk_rst = (reset === 1'b1);
    if (chk_rst) begin
      nb = 1'b0;
      nd = 1'b0;
      no = 1'b0;
    end
    exp_busy = nb;
    exp_done = nd;
    exp_ovr  = no;
  endtask

  task automatic slave_step();
    case (k_af_mode)
      2: fifo_almost_full = ($urandom_range(0, 3) == 0);
      1: begin
        if (af_phase == 1) begin
          if (af_hold == 0) begin
            fifo_almost_full = 1'b0;
            af_phase = 2;
            af_drop_at = negcnt;
            af_check_pending = 1'b1;
          end else af_hold--;
        end else fifo_almost_full = 1'b0;
      end
      default: fifo_almost_full = 1'b0;
    endcase

    avm_readdatavalid = 1'b0;
    avm_readdata      = $urandom;
    if (beats_pend > 0) begin
      if (lat_cnt > 0) lat_cnt--;
      else if (!k_gaps || $urandom_range(0, 3) != 0) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = mix(beat_addr);
        beat_addr         = beat_addr + 32'd4;
        beats_pend--;
        if (k_af_mode == 1 && af_phase == 0) begin
          af_phase = 1;
          af_hold = 40;
          fifo_almost_full = 1'b1;
        end
      end
    end

    if (reset === 1'b1) begin
      in_req = 1'b0;
      avm_waitrequest = 1'($urandom_range(0, 1));
    end else if (avm_read === 1'b1) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = avm_address;
        req_bc   = avm_burstcount;
        stall_left = k_rnd ? $urandom_range(0, 3) : ((burst_idx == k_stall_burst) ? k_stall_n : 0);
      end else begin
        check("stall_addr_stable", avm_address, req_addr);
        check("stall_bc_stable", 32'(avm_burstcount), 32'(req_bc));
      end
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
      end else begin
        avm_waitrequest = 1'b0;
        in_req = 1'b0;
        check1("burst_in_frame", (burst_idx < NB), 1'b1);
        if (burst_idx < NB) begin
          check("burst_addr", req_addr, exp_addr(burst_idx));
          check("burst_count", 32'(req_bc), 32'(exp_bc(burst_idx)));
        end
        last_grant_addr = req_addr;
        frame_grants++;
        burst_idx++;
        beats_pend = 32'(req_bc);
        beat_addr  = req_addr;
        lat_cnt    = k_rnd ? $urandom_range(0, 2) : k_lat;
      end
    end else begin
      if (in_req) begin
        check1("read_held_in_stall", avm_read, 1'b1);
        in_req = 1'b0;
      end
      avm_waitrequest = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    fifo_almost_full  = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      negcnt++;
      monitor_step();
      slave_step();
    end
  end

  typedef struct {
    int unsigned stall_burst;
    int unsigned stall_n;
    int unsigned lat;
    bit          gaps;
    bit          rnd;
    int unsigned af_mode;
    int unsigned exp_bursts;
    int unsigned exp_words;
    logic [31:0] exp_last;
  } scen_t;

  scen_t tbl[NSCEN];

  task automatic set_knobs(input int unsigned sb, input int unsigned sn, input int unsigned lat,
                           input bit gaps, input bit rnd, input int unsigned af);
    k_stall_burst = sb;
    k_stall_n     = sn;
    k_lat         = lat;
    k_gaps        = gaps;
    k_rnd         = rnd;
    k_af_mode     = af;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int unsigned c = 0;
    while (frame_done !== 1'b1 && c < 4000) begin
      @(negedge clk);
      c++;
    end
    check1({tag, "_frame_done_seen"}, frame_done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{99, 0, 1, 1'b0, 1'b0, 0, 7, 100, BASE + 32'h180}; // basic, data 2 cycles after grant
    tbl[1] = '{1,  5, 1, 1'b0, 1'b0, 0, 7, 100, BASE + 32'h180}; // 5-cycle stall on burst 2
    tbl[2] = '{99, 0, 1, 1'b0, 1'b0, 1, 7, 100, BASE + 32'h180}; // almost_full during burst 1
    tbl[3] = '{99, 0, 0, 1'b1, 1'b1, 2, 7, 100, BASE + 32'h180}; // random stalls/gaps/throttle
    tbl[4] = '{99, 0, 2, 1'b1, 1'b1, 2, 7, 100, BASE + 32'h180};

    reset = 1'b1;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NSCEN; i++) begin
      set_knobs(tbl[i].stall_burst, tbl[i].stall_n, tbl[i].lat, tbl[i].gaps, tbl[i].rnd, tbl[i].af_mode);
      pulse_start();
      wait_done("scen");
      check("scen_bursts", frame_grants, tbl[i].exp_bursts);
      check("scen_words", wr_idx, tbl[i].exp_words);
      check("scen_last_addr", last_grant_addr, tbl[i].exp_last);
      check1("scen_busy_clear", busy, 1'b0);
      repeat (4) @(negedge clk);
    end

    // Start coincident with frame_done is accepted without overrun.
    set_knobs(99, 0, 1, 1'b0, 1'b0, 0);
    pulse_start();
    wait_done("restart_a");
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check1("restart_busy", busy, 1'b1);
    wait_done("restart_b");
    check("restart_words", wr_idx, FW);
    check("restart_bursts", frame_grants, NB);
    check1("restart_no_overrun", start_overrun, 1'b0);
    repeat (3) @(negedge clk);

    // Start while busy: flagged, sticky, current frame unaffected.
    pulse_start();
    repeat (20) @(negedge clk);
    pulse_start();
    check1("overrun_set", start_overrun, 1'b1);
    wait_done("overrun");
    check("overrun_words", wr_idx, FW);
    repeat (3) @(negedge clk);
    check1("overrun_sticky", start_overrun, 1'b1);

    // Reset in the middle of the first burst; leftover beats must be dropped.
    pulse_start();
    for (int c = 0; c < 500 && wr_idx < 7; c++) @(negedge clk);
    check1("reset_mid_reached", (wr_idx >= 7), 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check1("reset_read", avm_read, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_overrun", start_overrun, 1'b0);
    check ("reset_address", avm_address, BASE);
    repeat (30) @(negedge clk);
    check("reset_leftover_drained", beats_pend, 0);
    pulse_start();
    wait_done("after_reset");
    check("after_reset_words", wr_idx, FW);
    check("after_reset_bursts", frame_grants, NB);
    check("after_reset_last_addr", last_grant_addr, BASE + 32'h180);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_fetch_ctrl.md
Name: frame_fetch_ctrl

Overview:
- Frame-buffer fetch engine on the memory-clock side of the VGA pixel path.
- Issues Avalon-MM burst reads from a linear frame buffer in SDRAM and writes the returned words into the async pixel FIFO.
- Drives the FIFO write-side pointer calculator's update_valid input and is throttled by that block's fifo_almost_full output.
- Re-armed once per frame by a start pulse already synchronised into this clock domain.

Parameters:
- addr_width, 32: Avalon byte-address width.
- data_width, 32: Avalon read data width; equals FIFO data width.
- base_addr, 32'h0000_0000: byte address of frame word 0.
- frame_words, 307200: words per frame (640x480, one 32-bit pixel per word).
- burst_len, 16: maximum words per burst; power of two, 1 to 64.

Ports:
- clk  in  1  memory-side clock.
- reset  in  1  synchronous, active-high.
- frame_start  in  1  single-cycle pulse requesting a full-frame fetch.
- fifo_almost_full  in  1  from the FIFO write-side calc; high means stop issuing new bursts.
- avm_address  out  addr_width  burst start byte address.
- avm_read  out  1  read request.
- avm_burstcount  out  7  words in the current burst.
- avm_waitrequest  in  1  slave stall.
- avm_readdata  in  data_width  returned data.
- avm_readdatavalid  in  1  returned-data strobe.
- fifo_wr_en  out  1  FIFO write strobe; connects to update_valid.
- fifo_wr_data  out  data_width  FIFO write data.
- busy  out  1  a frame fetch is in progress.
- frame_done  out  1  one-cycle pulse after the last word of a frame is written.
- start_overrun  out  1  sticky: frame_start was received while busy.

Behaviour:
- Reset values: avm_read=0, avm_address=base_addr, avm_burstcount=0, fifo_wr_en=0, fifo_wr_data=0, busy=0, frame_done=0, start_overrun=0, state=IDLE, all counters 0.
- Reset asserted mid-burst: the block returns to IDLE immediately. Any readdatavalid beats still in flight are ignored until the next frame_start. The system resets the FIFO together with this block.
- Counters:
  - req_remaining: words not yet requested; width ceil(log2(frame_words+1)).
  - beats_left: beats outstanding in the current burst; 7 bits.
  - rx_remaining: words not yet written to the FIFO.
- FSM states:
  - IDLE: on frame_start, load req_remaining and rx_remaining with frame_words, load avm_address with base_addr, set busy=1, go to CHECK.
  - CHECK: if fifo_almost_full=1, stay. Otherwise go to REQ with avm_burstcount = min(burst_len, req_remaining) and avm_read=1.
  - REQ: hold avm_read, avm_address and avm_burstcount stable while avm_waitrequest=1. On the first cycle with avm_read=1 and waitrequest=0:
    - drop avm_read;
    - beats_left <= burstcount;
    - req_remaining -= burstcount;
    - avm_address += burstcount*(data_width/8);
    - go to DATA.
  - DATA: each avm_readdatavalid decrements beats_left and rx_remaining. When beats_left reaches 0: if req_remaining=0 go to DONE, else go to CHECK.
  - DONE: wait for the last FIFO write to retire, pulse frame_done for 1 cycle, clear busy, go to IDLE.
- One burst is outstanding at a time.
- fifo_almost_full is sampled only in CHECK. A burst already granted always completes, which relies on FIFO headroom of at least burst_len above the almost-full threshold.
- Data path: fifo_wr_en and fifo_wr_data are registered copies of avm_readdatavalid and avm_readdata, so a beat appears on the FIFO side 1 cycle after readdatavalid.
- readdatavalid is accepted only in DATA state; beats in any other state are dropped.
- The final burst is short when frame_words is not a multiple of burst_len, e.g. the last burst is 4 words for frame_words=100, burst_len=16.
- Address arithmetic wraps modulo 2^addr_width; the block raises no error on wrap.
- frame_start while busy: ignored and sets start_overrun=1. start_overrun is cleared only by reset.
- frame_start in the same cycle as frame_done: accepted. IDLE is entered on the next cycle and a pulse arriving that cycle starts the next frame; no overrun is flagged.
- frame_done rises 1 cycle after the final fifo_wr_en.

Test Plan:
- Basic frame: frame_words=64, burst_len=16, waitrequest=0, readdatavalid 2 cycles after each grant, almost_full=0 -> 4 bursts at base_addr+0x00/0x40/0x80/0xC0, each with burstcount=16. 64 fifo_wr_en pulses with data in order, one frame_done, busy=0 afterwards.
- Short tail: frame_words=100, burst_len=16 -> 7 bursts (6 of 16 words, 1 of 4 words), exactly 100 FIFO writes, last burst address base_addr+0x180.
- Backpressure: waitrequest=1 for 5 cycles on burst 2 -> avm_read, address and burstcount remain stable through the stall. Exactly one grant occurs and no duplicate burst is issued.
- Throttle: almost_full=1 asserted during burst 1 data -> burst 1 completes all 16 beats. No avm_read while almost_full=1; the next burst is issued 1 cycle after almost_full drops.
- Overrun and restart: frame_start pulsed mid-frame -> start_overrun=1 and the current frame completes normally. frame_start coincident with frame_done -> new frame begins with avm_address=base_addr.
- Reset mid-burst: reset asserted after 7 of 16 beats -> all outputs at reset values the next cycle. The remaining 9 beats produce no fifo_wr_en, and a later frame_start fetches the full frame from base_addr.
